// File: rtl/syn_perf_counter_pkg.sv
// Shared core header for the performance counter slice: counter indices,
// select width and the packed per-cycle event vector.
package syn_perf_counter_pkg;

   localparam int NUM_CNT = 6;
   localparam int SEL_W   = 3;

   typedef enum logic [SEL_W-1:0] {
      CNT_CYCLES   = 3'd0,
      CNT_JUMPS    = 3'd1,
      CNT_BRANCHES = 3'd2,
      CNT_TAKEN    = 3'd3,
      CNT_BUBBLES  = 3'd4,
      CNT_LOAD_USE = 3'd5
   } cnt_idx_e;

   // Field order puts each event at the bit position of its counter index.
   typedef struct packed {
      logic load_use;
      logic bubble;
      logic branched;
      logic is_branch;
      logic jumped;
      logic cycle;
   } perf_evt_t;

   function automatic logic sel_valid(input logic [SEL_W-1:0] s);
      return s < SEL_W'(NUM_CNT);
   endfunction

endpackage

// File: rtl/syn_sat_counter.sv
// One saturating event counter with a sticky saturation flag.
module syn_sat_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] value,
   output logic                 sat
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         value <= '0;
         sat   <= 1'b0;
      end else if (inc) begin
         if (&value) sat   <= 1'b1;
         else        value <= value + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/syn_perf_counter.sv
// Core performance counters: six saturating counters, halt-triggered freeze
// and a registered readout mux.
module syn_perf_counter
   import syn_perf_counter_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 halted,
   input  logic                 jumped,
   input  logic                 is_branch,
   input  logic                 branched,
   input  logic                 bubble,
   input  logic                 load_use,
   input  logic [SEL_W-1:0]     sel,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic                 frozen,
   output logic                 ovf
);

   perf_evt_t                             evt;
   logic [NUM_CNT-1:0]                    inc;
   logic [NUM_CNT-1:0]                    sat;
   logic [NUM_CNT-1:0]                    sat_hit;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0]     value;
   logic [CNT_WIDTH-1:0]                  rd_val;
   logic                                  clr_en;
   logic                                  active;

   assign clr_en = en & clr;
   assign active = en & ~frozen & ~halted & ~clr;

   always_comb begin
      evt           = '0;
      evt.cycle     = 1'b1;
      evt.jumped    = jumped;
      evt.is_branch = is_branch;
      evt.branched  = branched;
      evt.bubble    = bubble;
      evt.load_use  = load_use;
   end

   assign inc = evt & {NUM_CNT{active}};

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      syn_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (clr_en),
         .inc   (inc[g]),
         .value (value[g]),
         .sat   (sat[g])
      );
      assign sat_hit[g] = inc[g] & (&value[g]);
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_CNT; i++)
         if (sel == SEL_W'(i)) rd_val = value[i];
   end

   // ovf tracks the flags' next state so it rises on the same edge as sat.
   always_ff @(posedge clk) begin
      if (rst) begin
         frozen    <= 1'b0;
         ovf       <= 1'b0;
         count_out <= '0;
      end else begin
         count_out <= sel_valid(sel) ? rd_val : '0;
         if (clr_en) begin
            frozen <= 1'b0;
            ovf    <= 1'b0;
         end else begin
            if (en & halted) frozen <= 1'b1;
            ovf <= |(sat | sat_hit);
         end
      end
   end

endmodule

// File: tb/tb_syn_perf_counter.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor checks them.
module tb_syn_perf_counter;

   logic        clk = 1'b0;
   logic        rst = 1'b1, en = 1'b0, clr = 1'b0, halted = 1'b0;
   logic        jumped = 1'b0, is_branch = 1'b0, branched = 1'b0;
   logic        bubble = 1'b0, load_use = 1'b0;
   logic [2:0]  sel = 3'd0;
   logic [31:0] count_out;
   logic        frozen, ovf;

   logic        rst4 = 1'b1, en4 = 1'b0, clr4 = 1'b0, jumped4 = 1'b0;
   logic [2:0]  sel4 = 3'd0;
   logic [3:0]  count_out4;
   logic        frozen4, ovf4;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      int          due;
      bit          narrow;
      int          kind;   // 0 count_out, 1 frozen, 2 ovf
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb[$];

   syn_perf_counter #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .halted(halted),
      .jumped(jumped), .is_branch(is_branch), .branched(branched),
      .bubble(bubble), .load_use(load_use), .sel(sel),
      .count_out(count_out), .frozen(frozen), .ovf(ovf)
   );

   syn_perf_counter #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .en(en4), .clr(clr4), .halted(1'b0),
      .jumped(jumped4), .is_branch(1'b0), .branched(1'b0),
      .bubble(1'b0), .load_use(1'b0), .sel(sel4),
      .count_out(count_out4), .frozen(frozen4), .ovf(ovf4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         sb_t e;
         logic [31:0] act;
         e = sb.pop_front();
         if (e.narrow)
            act = (e.kind == 0) ? {28'd0, count_out4} : (e.kind == 1) ? {31'd0, frozen4} : {31'd0, ovf4};
         else
            act = (e.kind == 0) ? count_out : (e.kind == 1) ? {31'd0, frozen} : {31'd0, ovf};
         total++;
         if (e.due != cyc) begin
            bad++;
            $display("FAIL %s: check overdue at cycle %0d (due %0d)", e.name, cyc, e.due);
         end else if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input bit nw, input int k, input logic [31:0] e, input string n);
      sb_t x;
      x.due = cyc + 1; x.narrow = nw; x.kind = k; x.exp = e; x.name = n;
      sb.push_back(x);
   endtask

   task automatic idle();
      en = 0; clr = 0; halted = 0; jumped = 0; is_branch = 0;
      branched = 0; bubble = 0; load_use = 0;
   endtask

   task automatic rd(input logic [2:0] s, input logic [31:0] e, input string n);
      sel = s;
      push(0, 0, e, n);
      tick();
   endtask

   task automatic rd4(input logic [2:0] s, input logic [31:0] e, input string n);
      sel4 = s;
      push(1, 0, e, n);
      tick();
   endtask

   initial begin
      tick(); tick();
      rst = 0; rst4 = 0;
      push(0, 1, 0, "rst_frozen");
      push(0, 2, 0, "rst_ovf");
      rd(0, 0, "rst_cycles");
      rd(1, 0, "rst_jumps");

      // 10 active cycles, jumped high for 3
      for (int i = 0; i < 10; i++) begin
         en = 1; jumped = (i < 3); tick();
      end
      idle();
      rd(0, 10, "run_cycles");
      rd(1, 3, "run_jumps");

      // branch / hazard events
      for (int i = 0; i < 4; i++) begin
         en = 1; is_branch = 1; branched = (i < 2);
         bubble = (i == 0); load_use = (i == 0); tick();
      end
      idle();
      rd(2, 4, "branches");
      rd(3, 2, "taken");
      rd(4, 1, "bubbles");
      rd(5, 1, "load_use");
      rd(0, 14, "cycles_after_br");
      rd(1, 3, "jumps_after_br");
      rd(6, 0, "sel6_zero");
      rd(7, 0, "sel7_zero");

      // halt freeze, then clear
      en = 1; clr = 1; tick(); idle();
      rd(0, 0, "clr_cycles");
      for (int i = 0; i < 7; i++) begin
         en = 1; jumped = (i < 2); tick();
      end
      for (int i = 0; i < 5; i++) begin
         en = 1; jumped = 1; halted = (i < 2); tick();
      end
      idle();
      push(0, 1, 1, "frozen_set");
      rd(0, 7, "frozen_cycles");
      rd(1, 2, "frozen_jumps");
      en = 1; clr = 1; halted = 1; jumped = 1; tick(); idle();
      push(0, 1, 0, "clr_unfreeze");
      rd(0, 0, "clr_frz_cycles");
      rd(1, 0, "clr_frz_jumps");

      // en=0 ignores events and clr
      for (int i = 0; i < 5; i++) begin
         en = 1; jumped = 1; tick();
      end
      for (int i = 0; i < 5; i++) begin
         en = 0; clr = 1; halted = 1; jumped = 1; is_branch = 1;
         branched = 1; bubble = 1; load_use = 1; tick();
      end
      idle();
      push(0, 1, 0, "en0_no_freeze");
      rd(0, 5, "en0_cycles");
      rd(1, 5, "en0_jumps");
      rd(2, 0, "en0_branches");

      // reset with clr mid-count
      for (int i = 0; i < 15; i++) begin
         en = 1; tick();
      end
      idle();
      rd(0, 20, "pre_rst_cycles");
      en = 1; halted = 1; tick(); idle();
      push(0, 1, 1, "pre_rst_frozen");
      rd(0, 20, "frozen_hold");
      sel = 0; en = 1; clr = 1; rst = 1; jumped = 1;
      push(0, 0, 0, "rst_edge_count");
      tick();
      rst = 0; idle();
      push(0, 1, 0, "rst_mid_frozen");
      push(0, 2, 0, "rst_mid_ovf");
      rd(0, 0, "rst_mid_cycles");
      rd(1, 0, "rst_mid_jumps");
      rd(5, 0, "rst_mid_sel5");
      rd(7, 0, "rst_mid_sel7");

      // 4-bit saturation
      for (int i = 0; i < 15; i++) begin
         en4 = 1; jumped4 = 1; tick();
      end
      en4 = 0; jumped4 = 0;
      push(1, 2, 0, "at_max_no_ovf");
      rd4(0, 15, "w4_cycles_max");
      rd4(1, 15, "w4_jumps_max");
      for (int i = 0; i < 2; i++) begin
         en4 = 1; tick();
      end
      en4 = 0;
      push(1, 2, 1, "w4_ovf_set");
      rd4(0, 15, "w4_cycles_sat");
      en4 = 1; clr4 = 1; tick(); en4 = 0; clr4 = 0;
      push(1, 2, 0, "w4_clr_ovf");
      rd4(0, 0, "w4_clr_cycles");
      for (int i = 0; i < 17; i++) begin
         en4 = 1; jumped4 = (i < 3); tick();
      end
      en4 = 0; jumped4 = 0;
      push(1, 2, 1, "w4_17_ovf");
      rd4(0, 15, "w4_17_cycles");
      rd4(1, 3, "w4_17_jumps");

      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      if (sb.size() > 0) begin
         bad += sb.size();
         total += sb.size();
         $display("FAIL drain: %0d checks never reached", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
